// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - time-multiplexed 4-digit common-anode seven-segment driver
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module seven_seg_scanner #(
    parameter int BLANK_CYCLES = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scan_clk,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CW = (BLANK_CYCLES < 1) ? 1 : $clog2(BLANK_CYCLES + 1);
    localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES);

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    logic          sync1_q, sync2_q, edge_q, tick_q;
    state_t        state_q;
    logic [1:0]    idx_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   snap_val_q;
    logic [3:0]    snap_dp_q;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;

    logic [3:0]    nib_d;
    logic [3:0]    an_drive_d;
    logic [6:0]    seg_drive_d;
    logic          dp_drive_d;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    // scan_clk is sampled as data; tick_q pulses one cycle per rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= scan_clk;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
            tick_q  <= sync2_q & ~edge_q;
        end
    end

    always_comb begin
        nib_d       = snap_val_q[{idx_q, 2'b00} +: 4];
        an_drive_d  = 4'hF;
        an_drive_d[idx_q] = 1'b0;
        seg_drive_d = hex_to_seg(nib_d);
        dp_drive_d  = ~snap_dp_q[idx_q];
`ifdef LEADING_ZERO_BLANK_EN
        if (!snap_dp_q[idx_q] &&
            (((idx_q == 2'd1) && (snap_val_q[15:4]  == 12'h000)) ||
             ((idx_q == 2'd2) && (snap_val_q[15:8]  == 8'h00))   ||
             ((idx_q == 2'd3) && (snap_val_q[15:12] == 4'h0)))) begin
            an_drive_d  = 4'hF;
            seg_drive_d = 7'h7F;
            dp_drive_d  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            cnt_q      <= '0;
            snap_val_q <= 16'h0000;
            snap_dp_q  <= 4'h0;
            an_q       <= 4'hF;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick_q) begin
                        idx_q      <= 2'd0;
                        snap_val_q <= value;
                        snap_dp_q  <= dp_in;
                        cnt_q      <= BLANK_LOAD;
                        state_q    <= BLANK;
                    end
                end
                BLANK: begin
                    if (cnt_q == '0) begin
                        an_q    <= an_drive_d;
                        seg_q   <= seg_drive_d;
                        dp_q    <= dp_drive_d;
                        state_q <= DRIVE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DRIVE: begin
                    if (tick_q) begin
                        // frame boundary: take a fresh coherent snapshot for digits 0..3
                        if (idx_q == 2'd3) begin
                            snap_val_q <= value;
                            snap_dp_q  <= dp_in;
                        end
                        idx_q   <= idx_q + 2'd1;
                        cnt_q   <= BLANK_LOAD;
                        an_q    <= 4'hF;
                        seg_q   <= 7'h7F;
                        dp_q    <= 1'b1;
                        state_q <= BLANK;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - self-checking bench for seven_seg_scanner
// Honours LEADING_ZERO_BLANK_EN in its expectations when defined.
module tb_seven_seg_scanner;

    localparam int B = 50;
    localparam logic [11:0] OFF = 12'hFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scan_clk = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_checks = 0;
    int n_err = 0;

    seven_seg_scanner #(.BLANK_CYCLES(B)) dut (
        .clk(clk), .rst_n(rst_n), .scan_clk(scan_clk),
        .value(value), .dp_in(dp_in), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [15:0] v;
        logic [3:0]  d;
        logic [11:0] e;
    } vec_t;
    vec_t tbl [12];

    // reference model: digit position within a frame plus the frame's snapshot
    bit          m_active = 0;
    int          m_k = 0;
    logic [15:0] m_val = 16'h0;
    logic [3:0]  m_dp = 4'h0;

    function automatic logic [11:0] mk(input logic [3:0] a, input logic [6:0] s, input logic d);
        return {a, s, d};
    endfunction

    function automatic logic [11:0] model_drive(input int k, input logic [15:0] v, input logic [3:0] d);
        logic [3:0]  a;
        logic [15:0] sh;
        logic [3:0]  nib;
        logic [11:0] r;
        a = 4'hF;
        a[k] = 1'b0;
        sh = v >> (4 * k);
        nib = sh[3:0];
        r = {a, hex_lut[nib], ~d[k]};
`ifdef LEADING_ZERO_BLANK_EN
        if (k > 0 && sh == 16'h0 && !d[k]) r = OFF;
`endif
        return r;
    endfunction

    task automatic model_edge(output logic [11:0] e);
        if (!m_active) begin
            m_active = 1;
            m_k = 0;
        end else begin
            m_k = (m_k + 1) % 4;
        end
        if (m_k == 0) begin
            m_val = value;
            m_dp = dp_in;
        end
        e = model_drive(m_k, m_val, m_dp);
    endtask

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {an,seg,dp}=%h expected %h", name, act, exp);
        end
    endtask

    // one scan_clk rising edge; checks latency, blank window length and driven digit
    task automatic step(input logic [11:0] e, input logic [11:0] prev, input string tag);
        @(posedge clk);
        #1 scan_clk = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({tag, "_pre"}, {an, seg, dp}, prev);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_blank_first"}, {an, seg, dp}, OFF);
        scan_clk = 1'b0;
        repeat (B) @(negedge clk);
        chk({tag, "_blank_last"}, {an, seg, dp}, OFF);
        @(negedge clk);
        chk({tag, "_drive"}, {an, seg, dp}, e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] e, prev, tmp;

        tbl[0] = '{16'h12AF, 4'h0, mk(4'hE, 7'h0E, 1'b1)};
        tbl[1] = '{16'h12AF, 4'h0, mk(4'hD, 7'h08, 1'b1)};
        tbl[2] = '{16'h8888, 4'h0, mk(4'hB, 7'h24, 1'b1)};
        tbl[3] = '{16'h8888, 4'h0, mk(4'h7, 7'h79, 1'b1)};
        tbl[4] = '{16'h8888, 4'h4, mk(4'hE, 7'h00, 1'b1)};
        tbl[5] = '{16'h8888, 4'h4, mk(4'hD, 7'h00, 1'b1)};
        tbl[6] = '{16'h8888, 4'h4, mk(4'hB, 7'h00, 1'b0)};
        tbl[7] = '{16'h0005, 4'h0, mk(4'h7, 7'h00, 1'b1)};
        tbl[8] = '{16'h0005, 4'h0, mk(4'hE, 7'h12, 1'b1)};
`ifdef LEADING_ZERO_BLANK_EN
        tbl[9]  = '{16'h0005, 4'h0, OFF};
        tbl[10] = '{16'h0005, 4'h0, OFF};
        tbl[11] = '{16'h0005, 4'h0, OFF};
`else
        tbl[9]  = '{16'h0005, 4'h0, mk(4'hD, 7'h40, 1'b1)};
        tbl[10] = '{16'h0005, 4'h0, mk(4'hB, 7'h40, 1'b1)};
        tbl[11] = '{16'h0005, 4'h0, mk(4'h7, 7'h40, 1'b1)};
`endif

        // reset held while scan_clk toggles
        for (int i = 0; i < 6; i++) begin
            repeat (3) @(posedge clk);
            #1 scan_clk = ~scan_clk;
            @(negedge clk);
            chk("reset_hold", {an, seg, dp}, OFF);
        end
        @(posedge clk);
        #1 scan_clk = 1'b0;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_static", {an, seg, dp}, OFF);

        prev = OFF;
        for (int i = 0; i < 12; i++) begin
            value = tbl[i].v;
            dp_in = tbl[i].d;
            model_edge(tmp);
            step(tbl[i].e, prev, $sformatf("tbl%0d", i));
            prev = tbl[i].e;
        end

        // second rising edge inside BLANK must be ignored
        value = 16'($urandom);
        dp_in = 4'($urandom);
        model_edge(e);
        @(posedge clk);
        #1 scan_clk = 1'b1;
        repeat (4) @(posedge clk);
        #1 scan_clk = 1'b0;
        repeat (4) @(posedge clk);
        #1 scan_clk = 1'b1;
        repeat (4) @(posedge clk);
        #1 scan_clk = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        chk("blank_ignore", {an, seg, dp}, e);
        prev = e;
        value = 16'($urandom);
        model_edge(e);
        step(e, prev, "after_ignore");
        prev = e;

        // walk to digit 2, then reset mid-DRIVE
        for (int i = 0; i < 4 && m_k != 2; i++) begin
            model_edge(e);
            step(e, prev, "to_digit2");
            prev = e;
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midop_reset", {an, seg, dp}, OFF);
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_active = 0;
        repeat (10) @(negedge clk);
        chk("post_reset_idle", {an, seg, dp}, OFF);
        prev = OFF;
        value = 16'($urandom);
        dp_in = 4'($urandom);
        model_edge(e);
        step(e, prev, "post_reset_d0");
        prev = e;

        // randomized values and gaps against the frame model
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 7)) @(posedge clk);
            value = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            dp_in = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            model_edge(e);
            step(e, prev, $sformatf("rand%0d", i));
            prev = e;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. It consumes the slow square wave from the clock divider as its scan rate and advances one digit per rising edge of that wave. For each digit it decodes a hex nibble of a 16-bit value onto active-low segment and anode lines, and inserts a short all-anodes-off interval between digits to prevent ghosting. It sits directly downstream of the clock divider and drives the display pins.

## Interface
- `BLANK_CYCLES`, default 50 — `clk` cycles with all anodes off after each digit change (1 µs at 50 MHz); 0 allowed.
- `clk`  in  1  — 50 MHz system clock.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `scan_clk`  in  1  — divided clock from the clock divider; treated as data, never used as a clock.
- `value`  in  16  — hex value to display; digit 0 = `value[3:0]`, rightmost.
- `dp_in`  in  4  — decimal point request per digit, active-high.
- `an`  out  4  — anode enables, active-low, one-hot-low when driving.
- `seg`  out  7  — {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  — decimal point, active-low.

## Operation
- `scan_clk` passes through a 2-FF synchronizer plus one edge-detect register. A rising edge produces a 1-cycle internal `tick`; falling edges are ignored.
- State machine: IDLE, BLANK, DRIVE.
  - IDLE (reset state): outputs off. On `tick`: digit index := 0, snapshot `value` and `dp_in`, load blank counter, go to BLANK.
  - BLANK: `an` = 4'hF, `seg` = 7'h7F, `dp` = 1. Counter decrements; at 0 go to DRIVE. `tick` in BLANK is ignored; no index change, counter not reloaded.
  - DRIVE: `an[idx]` = 0, others 1; `seg` = hex decode of snapshot nibble `idx`; `dp` = ~snapshot `dp_in[idx]`. On `tick`: idx := idx+1 mod 4 (3→0 wraps), reload counter, go to BLANK. On wrap to 0, re-snapshot `value`/`dp_in`, so all four digits of one frame show a coherent value.
- Hex decode, `seg` hex: 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E.
- Blank counter width is $clog2(BLANK_CYCLES+1), minimum 1 bit. With `BLANK_CYCLES` = 0, BLANK lasts exactly one cycle.

## Timing
- Reset (async assert, sync-released by design): `an` = 4'hF, `seg` = 7'h7F, `dp` = 1, state IDLE, idx = 0, synchronizer/edge regs = 0.
- All outputs are registered; there is no combinational path from any input to any output.
- Latency from a `scan_clk` rising edge (sampled at `clk` edge N) to `tick` high: cycle N+2.
- From `tick` to BLANK outputs: +1 cycle. From BLANK entry to DRIVE outputs: BLANK_CYCLES+1 cycles.
- `scan_clk` high-time and low-time must each be at least 3 `clk` cycles; shorter pulses may be missed.
- Mid-operation reset returns to IDLE immediately. The first post-reset `tick` starts again at digit 0 with a fresh snapshot.
- `value` changes between frame wraps have no effect until the next wrap to digit 0.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined: in DRIVE, digit `idx` with `idx` > 0 is suppressed (`an` = 4'hF, `seg` = 7'h7F, `dp` = 1) if its snapshot nibble and all higher nibbles are 0. This applies only when that digit's snapshot `dp_in` bit is also 0. Digit 0 is never suppressed.
- Undefined: every digit is always driven, including leading zeros.

## Test plan
- Reset held, toggle `scan_clk` → `an` = F, `seg` = 7F, `dp` = 1 throughout; after release with `scan_clk` static, outputs stay off.
- `value` = 16'h12AF, `dp_in` = 0, BLANK_CYCLES = 50, four `scan_clk` rising edges → each edge gives 51 cycles of `an` = F, then the digits in order:
  - `an` = E, `seg` = 0E
  - `an` = D, `seg` = 08
  - `an` = B, `seg` = 24
  - `an` = 7, `seg` = 79
- A 5th edge wraps to `an` = E. Check the edge→BLANK latency is exactly 3 cycles.
- Change `value` to 16'h8888 while digit 1 is driven → digits 2 and 3 still show 2 and 1; after the wrap, all digits show `seg` = 00.
- `dp_in` = 4'b0100 → `dp` = 0 only while `an` = B.
- `value` = 16'h0005 with the macro defined → `an` = E, `seg` = 12 on digit 0, and `an` = F during digits 1–3. Without the macro, digits 1–3 show `seg` = 40.
- Pulse `rst_n` low for 1 cycle mid-DRIVE on digit 2 → outputs off on the next clock edge, state IDLE; the next edge drives digit 0.
